// File: rtl/map_ss_seq.sv
// Save-state sequencer: dumps mapper state to a byte stream and replays a byte stream back into the mapper.
// Latency: dump byte RD_LAT+1 clk after its address is driven; restore write 2*M2_HALF+1 clk per byte.
// Backpressure: dout_rdy low parks the sequencer in D_PUSH; din_vld low parks it in R_GET; nothing is lost.
module map_ss_seq #(
   parameter int N_REGS  = 128,
   parameter int RD_LAT  = 2,
   parameter int M2_HALF = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_dump,
   input  logic       cmd_rest,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] map_idx,
   output logic       ss_act,
   output logic [7:0] ss_addr,
   output logic       ss_we,
   output logic       ss_m2,
   output logic [7:0] ss_wdat,
   input  logic [7:0] ss_rdat,
   output logic [7:0] dout,
   output logic       dout_vld,
   input  logic       dout_rdy,
   input  logic [7:0] din,
   input  logic       din_vld,
   output logic       din_rdy
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_D_SET,
      S_D_WAIT,
      S_D_PUSH,
      S_R_GET,
      S_R_SET,
      S_R_HI,
      S_R_LO,
      S_R_CHK,
      S_FIN
   } state_t;

   // Last state address; it holds the read-only map index and is never written.
   localparam logic [7:0] A_LAST  = 8'(N_REGS - 1);
   localparam logic [7:0] RD_LAST = (RD_LAT > 0) ? 8'(RD_LAT - 1) : 8'd0;
   localparam logic [7:0] M2_LAST = 8'(M2_HALF - 1);
   // With no read latency the readback is sampled in the cycle the address is first driven.
   localparam bit         RD_NONE = (RD_LAT == 0);

   state_t     state;
   state_t     nxt;
   logic [7:0] addr_q;
   logic [7:0] cnt_q;
   logic [7:0] byte_q;
   logic [7:0] dout_q;
   logic [7:0] map_idx_q;
   logic       err_q;

   logic       at_last;
   logic       wait_end;
   logic       m2_end;
   logic       sample;
   logic       chk_now;

   assign at_last  = (addr_q == A_LAST);
   assign wait_end = (cnt_q == RD_LAST);
   assign m2_end   = (cnt_q == M2_LAST);
   assign sample   = ((state == S_D_SET) && RD_NONE) || ((state == S_D_WAIT) && wait_end);
   assign chk_now  = (state == S_R_CHK) && (RD_NONE || wait_end);

   // State register; reset aborts any sequence immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Next-state decode; dump wins when both commands arrive together.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_dump) begin
               nxt = S_D_SET;
            end else if (cmd_rest) begin
               nxt = S_R_GET;
            end
         end
         S_D_SET:  nxt = RD_NONE ? S_D_PUSH : S_D_WAIT;
         S_D_WAIT: nxt = wait_end ? S_D_PUSH : S_D_WAIT;
         S_D_PUSH: begin
            if (dout_rdy) begin
               nxt = at_last ? S_FIN : S_D_SET;
            end
         end
         S_R_GET: begin
            if (din_vld) begin
               nxt = at_last ? S_R_CHK : S_R_SET;
            end
         end
         S_R_SET:  nxt = S_R_HI;
         S_R_HI:   nxt = m2_end ? S_R_LO : S_R_HI;
         S_R_LO:   nxt = m2_end ? S_R_GET : S_R_LO;
         S_R_CHK:  nxt = chk_now ? S_FIN : S_R_CHK;
         S_FIN:    nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
   end

   // Address walk, phase counter and data capture for both directions.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= 8'd0;
         cnt_q     <= 8'd0;
         byte_q    <= 8'd0;
         dout_q    <= 8'd0;
         map_idx_q <= 8'd0;
         err_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_dump || cmd_rest) begin
                  addr_q <= 8'd0;
                  cnt_q  <= 8'd0;
                  err_q  <= 1'b0;
               end
            end
            S_D_SET: begin
               cnt_q <= 8'd0;
            end
            S_D_WAIT: begin
               if (!wait_end) begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_D_PUSH: begin
               if (dout_rdy && !at_last) begin
                  addr_q <= addr_q + 8'd1;
               end
            end
            S_R_GET: begin
               cnt_q <= 8'd0;
               if (din_vld) begin
                  byte_q <= din;
               end
            end
            S_R_SET: begin
               cnt_q <= 8'd0;
            end
            S_R_HI: begin
               cnt_q <= m2_end ? 8'd0 : cnt_q + 8'd1;
            end
            S_R_LO: begin
               if (m2_end) begin
                  cnt_q  <= 8'd0;
                  addr_q <= addr_q + 8'd1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_R_CHK: begin
               if (chk_now) begin
                  err_q <= (byte_q != ss_rdat);
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_FIN: begin
               addr_q <= 8'd0;
            end
            default: begin
               addr_q <= 8'd0;
            end
         endcase
         // Readback capture is shared by D_SET (no latency) and D_WAIT.
         if (sample) begin
            dout_q <= ss_rdat;
            if (at_last) begin
               map_idx_q <= ss_rdat;
            end
         end
      end
   end

   // Outputs decoded from state; write strobes only exist in the restore write phases.
   always_comb begin
      busy     = (state != S_IDLE) && (state != S_FIN);
      ss_act   = busy;
      done     = (state == S_FIN);
      dout_vld = (state == S_D_PUSH);
      din_rdy  = (state == S_R_GET);
      ss_we    = (state == S_R_SET) || (state == S_R_HI) || (state == S_R_LO);
      ss_m2    = (state == S_R_HI);
      ss_addr  = busy ? addr_q : 8'd0;
      ss_wdat  = ss_we ? byte_q : 8'd0;
      dout     = dout_q;
      err      = err_q;
      map_idx  = map_idx_q;
   end

endmodule
